tdc_uart_framer: RTL and testbench

//  Upstream feeder for the RS-232 transmitter. Buffers 32-bit TDC measurement words
//  and sends each one as a 6-byte frame: SYNC, data bytes MSB first, then checksum.

---
 rtl/tdc_uart_pkg.sv | 31 +++
 rtl/tdc_uart_framer_sync_fifo.sv | 60 ++++++
 rtl/tdc_uart_framer.sv | 112 +++++++++++
 tb/tb_tdc_uart_framer.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tdc_uart_pkg.sv
// Shared constants for the TDC-to-UART framer: frame layout, FSM encoding
// and the byte selector used to serialise one measurement word.
package tdc_uart_pkg;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
  localparam int         FRAME_LEN         = 6;

  // Framer FSM encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_SEND = 2'd2;
  localparam logic [1:0] ST_WAIT = 2'd3;

  // Byte idx of a frame: sync, four data bytes MSB first, XOR checksum.
  function automatic logic [7:0] frame_byte(input logic [31:0] w,
                                            input logic [2:0]  idx,
                                            input logic [7:0]  sync);
    logic [7:0] b;
    case (idx)
      3'd0:    b = sync;
      3'd1:    b = w[31:24];
      3'd2:    b = w[23:16];
      3'd3:    b = w[15:8];
      3'd4:    b = w[7:0];
      3'd5:    b = w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/tdc_uart_framer_sync_fifo.sv
// Single-clock FIFO with registered pointers/level and a registered head read.
// The head word is re-read every cycle, so a pop sees data written at least
// two edges earlier; the framer never pops in consecutive cycles, which keeps
// the registered read current.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      level_o
);

  localparam logic [AW:0] FULL_LEVEL = {1'b1, {AW{1'b0}}};

  logic [WIDTH-1:0] mem_q [0:(1<<AW)-1];
  logic [WIDTH-1:0] rdata_q;
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      level_q;
  logic [AW:0]      level_d;

  // Push and pop may coincide at any level; the level simply nets them out
  assign level_d = level_q + (AW+1)'(push_i) - (AW+1)'(pop_i);

  // Storage array, no reset so it maps onto RAM
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  // Registered read of the current head entry
  always_ff @(posedge clk) begin
    rdata_q <= mem_q[rd_ptr_q];
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_d;
    end
  end

  assign rdata_o = rdata_q;
  assign full_o  = (level_q == FULL_LEVEL);
  assign empty_o = (level_q == '0);
  assign level_o = level_q;

endmodule

// File: rtl/tdc_uart_framer.sv
// Buffers 32-bit TDC words and hands each to the byte transmitter as a
// 6-byte frame (sync, data MSB first, XOR checksum), one byte per busy period.
module tdc_uart_framer
  import tdc_uart_pkg::*;
#(
  parameter int         FIFO_AW   = 4,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [31:0]        in_data,
  output logic               in_ready,
  output logic               tx_start,
  output logic [7:0]         tx_data,
  input  logic               tx_busy,
  output logic [FIFO_AW:0]   fifo_level,
  output logic [15:0]        frame_cnt
);

  logic [1:0]  state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [31:0] hold_q, hold_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic        wait_first_q, wait_first_d;

  logic        fifo_push;
  logic        fifo_pop;
  logic [31:0] fifo_rdata;
  logic        fifo_full;
  logic        fifo_empty;
  logic        send_active;

  assign fifo_push = in_valid & in_ready;
  assign fifo_pop  = (state_q == ST_LOAD);

  sync_fifo #(
    .WIDTH (32),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .wdata_i (in_data),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  // Next-state logic: load a word, then alternate SEND/WAIT for each byte
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    hold_d       = hold_q;
    frame_cnt_d  = frame_cnt_q;
    // The cycle right after a start is skipped because busy is not yet visible
    wait_first_d = (state_q == ST_SEND) && !tx_busy;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        hold_d  = fifo_rdata;
        idx_d   = 3'd0;
        state_d = ST_SEND;
      end
      ST_SEND: begin
        if (!tx_busy) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (!wait_first_q && !tx_busy) begin
          if (idx_q != 3'(FRAME_LEN - 1)) begin
            idx_d   = idx_q + 3'd1;
            state_d = ST_SEND;
          end else begin
            frame_cnt_d = frame_cnt_q + 16'd1;
            state_d     = fifo_empty ? ST_IDLE : ST_LOAD;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset abandons any frame in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      idx_q        <= 3'd0;
      hold_q       <= 32'd0;
      frame_cnt_q  <= 16'd0;
      wait_first_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      hold_q       <= hold_d;
      frame_cnt_q  <= frame_cnt_d;
      wait_first_q <= wait_first_d;
    end
  end

  // Start is combinational so it never fires in a cycle where busy is high
  // and drops in the very cycle reset is asserted.
  assign send_active = (state_q == ST_SEND) && !rst;
  assign tx_start    = send_active && !tx_busy;
  assign tx_data     = send_active ? frame_byte(hold_q, idx_q, SYNC_BYTE) : 8'h00;
  assign in_ready    = !fifo_full;
  assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_tdc_uart_framer.sv
// Self-checking bench for tdc_uart_framer with a 20-cycle busy transmitter model,
// a frame scoreboard fed from accepted pushes, and directed corner sequences.
module tb_tdc_uart_framer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = 32'd0;
  logic        in_ready;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy;
  logic [4:0]  fifo_level;
  logic [15:0] frame_cnt;

  always #5 clk = ~clk;

  tdc_uart_framer dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .tx_busy    (tx_busy),
    .fifo_level (fifo_level),
    .frame_cnt  (frame_cnt)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Transmitter model: busy for 20 cycles starting the cycle after a start
  int   busy_cnt = 0;
  logic force_busy = 1'b0;
  logic start_flag = 1'b0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (start_flag) busy_cnt <= 20;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = force_busy || (busy_cnt != 0);

  task automatic check(input string nm, input longint a, input longint e);
    checks++;
    if (a != e) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", nm, a, e);
    end
  endtask

  task automatic fail_now(input string nm, input string msg);
    checks++;
    failures++;
    $display("FAIL %s: %s", nm, msg);
  endtask

  // Reference frame: sync, the word MSB first, XOR of its four bytes
  function automatic logic [47:0] frame_of(input logic [31:0] w);
    logic [7:0] c;
    c = 8'h00;
    for (int i = 0; i < 4; i++) c ^= 8'(w >> (24 - 8 * i));
    return {8'hA5, w, c};
  endfunction

  // Scoreboard / protocol monitor
  logic [7:0] exp_q[$];
  logic [7:0] cap_q[$];
  int         start_cyc_q[$];
  int         pushes = 0;
  logic       prev_start = 1'b0;
  always @(negedge clk) begin
    logic [47:0] f;
    if (rst) begin
      exp_q.delete();
      pushes = 0;
    end else begin
      if (tx_start) begin
        check("start_while_busy", tx_busy, 0);
        check("start_width", prev_start, 0);
        if (exp_q.size() == 0) fail_now("unexpected_byte", $sformatf("byte %0h with no frame pending", tx_data));
        else check("frame_byte", tx_data, exp_q.pop_front());
        cap_q.push_back(tx_data);
        start_cyc_q.push_back(cyc);
      end
      if (in_valid && in_ready) begin
        f = frame_of(in_data);
        for (int i = 0; i < 6; i++) exp_q.push_back(f[47-8*i -: 8]);
        pushes++;
      end
    end
    prev_start = tx_start;
    start_flag = tx_start;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer a word until accepted; report acceptance cycle and pre-push level
  task automatic push_word(input logic [31:0] w, input int budget,
                           output int acc_cyc, output int acc_level);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = w;
    @(negedge clk);
    while (!in_ready && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) fail_now("push_timeout", $sformatf("word %h never accepted", w));
    acc_cyc   = cyc;
    acc_level = int'(fifo_level);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Wait until every expected byte went out, then check the quiescent state
  task automatic drain(input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) fail_now("drain_timeout", $sformatf("%0d bytes never sent", exp_q.size()));
    repeat (25) step();
    @(negedge clk);
    check("frame_cnt", frame_cnt, pushes & 16'hFFFF);
    check("idle_level", fifo_level, 0);
    check("idle_ready", in_ready, 1);
    check("idle_tx_data", tx_data, 0);
    step();
  endtask

  typedef struct {
    logic [31:0] word;
    logic [47:0] bytes;
  } vec_t;

  initial begin
    vec_t        vecs[5];
    logic [47:0] v;
    logic [95:0] two;
    int          ac, al, target, n;

    vecs[0] = '{32'h12345678, 48'hA5_12345678_08};
    vecs[1] = '{32'hDEADBEEF, 48'hA5_DEADBEEF_22};
    vecs[2] = '{32'h00000000, 48'hA5_00000000_00};
    vecs[3] = '{32'hFFFFFFFF, 48'hA5_FFFFFFFF_00};
    vecs[4] = '{32'hA5A5A5A5, 48'hA5_A5A5A5A5_00};

    // Reset values
    rst = 1'b1;
    repeat (3) step();
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_tx_start", tx_start, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_level", fifo_level, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    step();
    rst = 1'b0;
    step();

    // Single-word frames from an idle framer
    for (int k = 0; k < 5; k++) begin
      cap_q.delete();
      start_cyc_q.delete();
      push_word(vecs[k].word, 5, ac, al);
      drain(400);
      check("vec_nbytes", cap_q.size(), 6);
      v = vecs[k].bytes;
      for (int i = 0; i < 6 && i < cap_q.size(); i++)
        check($sformatf("vec%0d_byte%0d", k, i), cap_q[i], v[47-8*i -: 8]);
      if (start_cyc_q.size() == 6) begin
        check("first_byte_latency", start_cyc_q[0] - ac, 3);
        for (int i = 1; i < 6; i++)
          check("byte_spacing", start_cyc_q[i] - start_cyc_q[i-1], 22);
      end
    end

    // Back-to-back words stream with only the one-cycle LOAD gap
    cap_q.delete();
    start_cyc_q.delete();
    push_word(32'hDEADBEEF, 5, ac, al);
    push_word(32'h00000000, 5, ac, al);
    drain(800);
    two = 96'hA5_DEADBEEF_22_A5_00000000_00;
    check("b2b_nbytes", cap_q.size(), 12);
    for (int i = 0; i < 12 && i < cap_q.size(); i++)
      check($sformatf("b2b_byte%0d", i), cap_q[i], two[95-8*i -: 8]);
    if (start_cyc_q.size() == 12)
      for (int i = 1; i < 12; i++)
        check($sformatf("b2b_gap%0d", i), start_cyc_q[i] - start_cyc_q[i-1], (i == 6) ? 23 : 22);

    // Busy stuck high: the first word is loaded into the holding register,
    // so 17 words are taken before the FIFO reports 16 and stalls.
    cap_q.delete();
    force_busy = 1'b1;
    for (int k = 0; k < 17; k++) begin
      push_word($urandom, 5, ac, al);
      if (k == 16) check("full_prepush_level", al, 15);
    end
    @(negedge clk);
    check("full_level", fifo_level, 16);
    check("full_ready", in_ready, 0);
    step();
    in_valid = 1'b1;
    in_data  = 32'hCAFE0018;
    n = 0;
    repeat (8) begin
      @(negedge clk);
      if (in_ready) n++;
    end
    check("full_rejects", n, 0);
    check("no_start_while_stuck", cap_q.size(), 0);
    step();
    force_busy = 1'b0;
    push_word(32'hCAFE0018, 400, ac, al);
    check("refill_prepush_level", al, 15);
    drain(18 * 140 + 200);
    check("stuck_nbytes", cap_q.size(), 18 * 6);

    // Push and pop in the same cycle at level 1
    push_word(32'h13579BDF, 5, ac, al);
    step();
    push_word(32'h2468ACE0, 5, ac, al);
    check("pp_prepush_level", al, 1);
    @(negedge clk);
    check("pp_level_unchanged", fifo_level, 1);
    drain(500);

    // Reset in the SEND cycle of byte idx 3
    cap_q.delete();
    start_cyc_q.delete();
    push_word(32'h11223344, 5, ac, al);
    push_word(32'h55667788, 5, ac, al);
    n = 0;
    while (start_cyc_q.size() < 3 && n < 200) begin
      step();
      n++;
    end
    if (start_cyc_q.size() < 3) fail_now("rst_setup_timeout", "byte idx 2 never started");
    else begin
      target = start_cyc_q[2] + 22;
      n = 0;
      while (cyc < target && n < 100) begin
        step();
        n++;
      end
      rst = 1'b1;
      @(negedge clk);
      check("rst_drops_start", tx_start, 0);
      step();
      rst = 1'b0;
      @(negedge clk);
      check("midrst_level", fifo_level, 0);
      check("midrst_frame_cnt", frame_cnt, 0);
      check("midrst_ready", in_ready, 1);
      check("midrst_tx_data", tx_data, 0);
      step();
      cap_q.delete();
      push_word(32'h0BADF00D, 5, ac, al);
      drain(400);
      v = 48'hA5_0BADF00D_5B;
      check("post_rst_nbytes", cap_q.size(), 6);
      for (int i = 0; i < 6 && i < cap_q.size(); i++)
        check($sformatf("post_rst_byte%0d", i), cap_q[i], v[47-8*i -: 8]);
    end

    // Randomized words and gaps against the scoreboard
    for (int k = 0; k < 20; k++) begin
      push_word($urandom, 400, ac, al);
      repeat ($urandom_range(0, 60)) step();
    end
    drain(20 * 140 + 200);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
